// File: rtl/count_frame_rx_if.sv
// rtl/count_frame_rx_if.sv - UART line in, decoded bytes and counter frames out
interface count_frame_rx_if #(
    parameter int NUM_WORDS = 8
);
    logic                      rx;
    logic [NUM_WORDS*32-1:0]   counts;
    logic                      frame_valid;
    logic                      frame_err;
    logic                      byte_valid;
    logic [7:0]                byte_data;
    logic                      busy;

    modport slave (
        input  rx,
        output counts, frame_valid, frame_err, byte_valid, byte_data, busy
    );

    modport master (
        output rx,
        input  counts, frame_valid, frame_err, byte_valid, byte_data, busy
    );
endinterface

// File: rtl/count_frame_rx.sv
// rtl/count_frame_rx.sv - UART 8N1 receiver and count-report frame parser (optional FRAME_CHECKSUM_EN)
module count_frame_rx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         NUM_WORDS    = 8,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic            clk,
    input  logic            rst_n,
    count_frame_rx_if.slave bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int NB   = NUM_WORDS * 4;
    localparam int IW   = $clog2(NB + 1);
    localparam int TW   = NUM_WORDS * 32;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} parse_state_t;
`else
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD} parse_state_t;
`endif

    logic           rx_s1, rx_s2, rx_d;
    bit_state_t     bstate;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           byte_valid_r;
    logic [7:0]     byte_data_r;
    logic           frm_err_p;

    parse_state_t   pstate;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  shadow;
    logic [TW-1:0]  shadow_ins;
    logic [TW-1:0]  counts_r;
    logic           frame_valid_r;
    logic           frame_err_r;
    int             ins_lo;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]     xacc;
`endif

    // Two-flop synchroniser plus one delay stage for falling-edge detection; idle-high preset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= bus.rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Bit engine: mid-bit sampling; after a bad stop bit the edge detector needs rx high again before re-arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate       <= B_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            byte_valid_r <= 1'b0;
            byte_data_r  <= '0;
            frm_err_p    <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frm_err_p    <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        bstate <= B_START;
                        cnt    <= '0;
                    end
                end
                B_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        bstate  <= rx_s2 ? B_IDLE : B_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                B_DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) bstate <= B_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt    <= '0;
                        bstate <= B_IDLE;
                        if (rx_s2) begin
                            byte_valid_r <= 1'b1;
                            byte_data_r  <= shift;
                        end else begin
                            frm_err_p <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Shadow with the current byte placed big-endian inside its word; word 0 occupies the low bits
    always_comb begin
        ins_lo     = int'(idx[IW-1:2]) * 32 + (3 - int'(idx[1:0])) * 8;
        shadow_ins = shadow;
        shadow_ins[ins_lo +: 8] = byte_data_r;
    end

    // Frame parser: header lock, payload reassembly, optional xor check, publish to counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate        <= P_HUNT;
            idx           <= '0;
            shadow        <= '0;
            counts_r      <= '0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            xacc          <= '0;
`endif
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            if (frm_err_p) begin
                if (pstate != P_HUNT) frame_err_r <= 1'b1;
                pstate <= P_HUNT;
            end else if (byte_valid_r) begin
                case (pstate)
                    P_HUNT: begin
                        if (byte_data_r == HEADER) begin
                            pstate <= P_PAYLOAD;
                            idx    <= '0;
`ifdef FRAME_CHECKSUM_EN
                            xacc   <= '0;
`endif
                        end
                    end
                    P_PAYLOAD: begin
                        shadow <= shadow_ins;
                        idx    <= idx + IW'(1);
`ifdef FRAME_CHECKSUM_EN
                        xacc   <= xacc ^ byte_data_r;
                        if (idx == IW'(NB - 1)) pstate <= P_CHECK;
`else
                        if (idx == IW'(NB - 1)) begin
                            counts_r      <= shadow_ins;
                            frame_valid_r <= 1'b1;
                            pstate        <= P_HUNT;
                        end
`endif
                    end
`ifdef FRAME_CHECKSUM_EN
                    P_CHECK: begin
                        if (byte_data_r == xacc) begin
                            counts_r      <= shadow;
                            frame_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                        pstate <= P_HUNT;
                    end
`endif
                    default: pstate <= P_HUNT;
                endcase
            end
        end
    end

    assign bus.counts      = counts_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.byte_valid  = byte_valid_r;
    assign bus.byte_data   = byte_data_r;
    assign bus.busy        = (pstate != P_HUNT);
endmodule

// File: tb/tb_count_frame_rx.sv
// tb/tb_count_frame_rx.sv - self-checking bench for count_frame_rx
module tb_count_frame_rx;
    localparam int         CPB = 16;
    localparam int         NW  = 2;
    localparam logic [7:0] HDR = 8'hA5;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_frame_rx_if #(.NUM_WORDS(NW)) bus();

    count_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .NUM_WORDS(NW),
        .HEADER(HDR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        bit               good;
        logic [NW*32-1:0] cnt;
    } ev_t;

    int               errors = 0;
    int               checks = 0;
    int               n_fv   = 0;
    int               n_fe   = 0;
    logic [7:0]       exp_bytes[$];
    ev_t              ev_q[$];
    logic [NW*32-1:0] model_counts;
    logic             prev_bv;
    ev_t              ev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the byte/frame scoreboards
    always @(negedge clk) begin
        if (!rst_n) begin
            model_counts = '0;
            prev_bv      = 1'b0;
        end else begin
            if (bus.byte_valid) begin
                check("byte_expected", exp_bytes.size() != 0, 1);
                if (exp_bytes.size() != 0) check("byte_data", bus.byte_data, exp_bytes.pop_front());
            end
            if (bus.frame_valid && bus.frame_err) check("fv_fe_exclusive", 1, 0);
            if (bus.frame_valid) begin
                n_fv++;
                check("fv_latency", prev_bv, 1);
                check("fv_expected", ev_q.size() != 0, 1);
                if (ev_q.size() != 0) begin
                    ev = ev_q.pop_front();
                    check("fv_kind", ev.good, 1);
                    model_counts = ev.cnt;
                end
            end
            if (bus.frame_err) begin
                n_fe++;
                check("fe_expected", ev_q.size() != 0, 1);
                if (ev_q.size() != 0) begin
                    ev = ev_q.pop_front();
                    check("fe_kind", ev.good, 0);
                end
            end
            check("counts", bus.counts, model_counts);
            prev_bv = bus.byte_valid;
        end
    end

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (stop) exp_bytes.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    // Frame = header, words big-endian (word 0 first), then xor byte when enabled; bad frames use 8'h00
    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1, input bit bad);
        logic [7:0]  x;
        logic [63:0] words;
        ev_t         e;
        words  = {w1, w0};
        x      = 8'h00;
        e.good = !bad;
        e.cnt  = words;
        ev_q.push_back(e);
        send_byte(HDR, 1'b1);
        check("busy_after_header", bus.busy, 1);
        for (int w = 0; w < NW; w++)
            for (int k = 3; k >= 0; k--) begin
                send_byte(words[w*32 + k*8 +: 8], 1'b1);
                x ^= words[w*32 + k*8 +: 8];
            end
        if (CHK_EN) send_byte(bad ? 8'h00 : x, 1'b1);
    endtask

    initial begin
        ev_t e;
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_counts", bus.counts, 0);
        check("rst_fv", bus.frame_valid, 0);
        check("rst_fe", bus.frame_err, 0);
        check("rst_bv", bus.byte_valid, 0);
        check("rst_bd", bus.byte_data, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single non-header byte
        send_byte(8'h3C, 1'b1);
        check("single_byte_data", bus.byte_data, 8'h3C);
        check("single_busy", bus.busy, 0);
        check("single_no_frame", n_fv, 0);

        // good frame 300 / 7 (xor 8'h2A)
        send_frame(32'd300, 32'd7, 1'b0);
        check("frame1_counts", bus.counts, 64'h00000007_0000012C);
        check("frame1_nfv", n_fv, 1);
        check("frame1_busy", bus.busy, 0);

        // bad checksum keeps counts
        if (CHK_EN) begin
            send_frame(32'd300, 32'd7, 1'b1);
            check("badchk_counts", bus.counts, 64'h00000007_0000012C);
            check("badchk_nfe", n_fe, 1);
            check("badchk_nfv", n_fv, 1);
            check("badchk_busy", bus.busy, 0);
        end

        // short glitch, then a clean byte
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h55, 1'b1);
        check("glitch_then_55", bus.byte_data, 8'h55);

        // framing error while hunting: silent
        send_byte(8'h12, 1'b0);
        check("hunt_ferr_busy", bus.busy, 0);

        // framing error on third payload byte
        e.good = 1'b0;
        e.cnt  = '0;
        ev_q.push_back(e);
        send_byte(HDR, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b0);
        check("ferr_busy", bus.busy, 0);
        check("ferr_counts", bus.counts, 64'h00000007_0000012C);

        // recovery frame carrying a header value as data
        send_frame(32'hDEADBEEF, 32'h00A50001, 1'b0);
        check("recover_counts", bus.counts, 64'h00A50001_DEADBEEF);

        // reset mid-payload
        send_byte(HDR, 1'b1);
        send_byte(8'h11, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        bus.rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        bus.rx = 1'b1;
        #1;
        check("midrst_counts", bus.counts, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_fv", bus.frame_valid, 0);
        check("midrst_fe", bus.frame_err, 0);
        check("midrst_bv", bus.byte_valid, 0);
        check("midrst_bd", bus.byte_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(32'd1, 32'd2, 1'b0);
        check("postrst_counts", bus.counts, 64'h00000002_00000001);

        repeat (3 * CPB) @(negedge clk);
        check("bytes_drained", exp_bytes.size(), 0);
        check("events_drained", ev_q.size(), 0);
        check("total_fv", n_fv, 3);
        check("total_fe", n_fe, CHK_EN ? 2 : 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        errors++;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/count_frame_rx.md
Name: count_frame_rx

Overview:
- UART receiver plus frame parser for the count-report stream that the coincidence counter emits on `tx`.
- Deserialises bytes and locks onto the frame header.
- Reassembles NUM_WORDS big-endian 32-bit counters and presents them as a flat parallel bus with a one-cycle valid strobe.
- Used as the host-side loopback/checker block in the coincidence-counting FPGA, and as the command-side receiver template.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 8.
- NUM_WORDS, 8, counters per frame (A, B, BP, AP singles + 4 coincidence channels).
- HEADER, 8'hA5, frame sync byte.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  UART line, idle high, 8N1, LSB first
- counts  output  NUM_WORDS*32  received counters; word 0 in bits [31:0]
- frame_valid  output  1  one-cycle pulse, counts updated this cycle
- frame_err  output  1  one-cycle pulse on framing or checksum error
- byte_valid  output  1  one-cycle pulse per received byte
- byte_data  output  8  last received byte, valid with byte_valid
- busy  output  1  high while the parser is outside HUNT

Behaviour:
- Reset (async, rst_n=0): all outputs 0, parser in HUNT, bit engine in IDLE, synchroniser flops preset to 1.
- rx passes through a 2-flop synchroniser. All references to rx below mean the synchronised value.

Bit engine states: IDLE, START, DATA, STOP.
- IDLE: a 1->0 transition moves to START, counter cleared.
- START: at CLKS_PER_BIT/2 cycles, sample rx. If 0, go to DATA. If 1 (glitch), return to IDLE with no strobe.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rx=1: byte_valid=1 and byte_data updated next cycle; return to IDLE.
  - rx=0: framing error; no byte_valid; frame_err pulses only if the parser is outside HUNT; parser forced to HUNT; engine waits in IDLE for rx=1 before re-arming.

Frame parser states: HUNT, PAYLOAD, CHECK. It consumes one byte per byte_valid.
- HUNT: a byte equal to HEADER moves to PAYLOAD with byte index 0 and xor accumulator 0. Any other byte is ignored.
- PAYLOAD: bytes shift into a shadow register, MSB first within each word, word 0 first. The xor accumulator folds in every payload byte. A HEADER value inside the payload is treated as data. After NUM_WORDS*4 bytes, move to CHECK.
- CHECK: the next byte is compared to the xor accumulator.
  - Equal: counts <= shadow and frame_valid=1, both in the cycle after that byte's byte_valid.
  - Mismatch: frame_err=1 in the same cycle; counts unchanged.
  - Either way, return to HUNT.

Timing and other rules:
- counts holds its value until the next good frame. The shadow register is never visible on counts.
- Latency: frame_valid is 1 cycle after the byte_valid of the final byte, i.e. 2 cycles after the stop-bit sample.
- frame_valid and frame_err are never high together.
- busy = (parser != HUNT).
- Reset mid-frame discards the partial frame; counts return to 0.

Optional Feature:
- Macro FRAME_CHECKSUM_EN.
- Defined: CHECK state present and the frame carries a trailing xor byte, as described above.
- Undefined: no CHECK state and no checksum byte. The frame completes on the last payload byte (counts updated, frame_valid 1 cycle later), and frame_err fires only on framing errors.

Test Plan (CLKS_PER_BIT=16, NUM_WORDS=2, FRAME_CHECKSUM_EN defined):
- Single byte 8'h3C driven at 16 clk/bit -> byte_valid pulses once, byte_data=8'h3C; no frame_valid; busy stays 0.
- Frame A5, 00 00 01 2C, 00 00 00 07, chk 8'h2A -> frame_valid 1 cycle after the last byte_valid; counts[31:0]=300, counts[63:32]=7; frame_err=0.
- Same frame with chk 8'h00 -> frame_err pulses once, frame_valid=0, counts keeps its previous value (300/7 after the prior test); parser returns to HUNT (busy=0).
- rx held low for 4 cycles then high (short glitch) -> no byte_valid; the engine then receives the following 8'h55 correctly.
- Stop bit forced 0 on the 3rd payload byte -> frame_err pulses, busy=0; a subsequent full valid frame is accepted normally.
- rst_n pulsed low mid-payload -> all outputs 0 immediately; a following valid frame yields correct counts.
